rom_arbiter: RTL and testbench

ROM_ARBITER -- requirements
Module: rom_arbiter

---
 rtl/rom_arb_pkg.sv | 14 +
 rtl/rom_arbiter_rom.sv | 25 ++
 rtl/rom_arbiter.sv | 92 +++++++++
 tb/tb_rom_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rom_arb_pkg.sv
// Shared types and widths for the two-port ROM arbiter.
// Holds the FSM state encoding and the requester-ID width.
package rom_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  localparam int ID_W   = 1;
  localparam int ADDR_W = 3;
  localparam int DATA_W = 8;

endpackage

// File: rtl/rom_arbiter_rom.sv
// Shared 8-entry lookup ROM.
// Purely combinational: the data follows the address in the same cycle.
module ROM
  import rom_arb_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  always_comb begin
    data = '0;
    case (addr)
      3'd0: data = 8'h33;
      3'd1: data = 8'hCC;
      3'd2: data = 8'h55;
      3'd3: data = 8'hAA;
      3'd4: data = 8'hF0;
      3'd5: data = 8'h0F;
      3'd6: data = 8'h81;
      3'd7: data = 8'h7E;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/rom_arbiter.sv
// Two-requester arbiter in front of one shared ROM.
// Holds one response at a time and accepts a new read when the held one is taken.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int FAIR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [ADDR_W-1:0] req0_addr,
  output logic              req0_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_data,
  input  logic              rsp0_ready,
  input  logic              req1_valid,
  input  logic [ADDR_W-1:0] req1_addr,
  output logic              req1_ready,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_data,
  input  logic              rsp1_ready
);

  state_t            state_q, state_d;
  logic [ID_W-1:0]   id_q, id_d;
  logic [ID_W-1:0]   last_q, last_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [ID_W-1:0]   gnt;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic              take;
  logic              accept;

  ROM u_rom (
    .addr (rom_addr),
    .data (rom_data)
  );

  always_comb begin
    // On a tie, round-robin favours whoever did not win last time.
    if (req0_valid && req1_valid) begin
      gnt = (FAIR != 0) ? ~last_q : ID_W'(0);
    end else if (req1_valid) begin
      gnt = ID_W'(1);
    end else begin
      gnt = ID_W'(0);
    end

    take   = (state_q == RESP) &&
             ((id_q == ID_W'(0)) ? rsp0_ready : rsp1_ready);
    accept = ((state_q == IDLE) || take) && (req0_valid || req1_valid);

    req0_ready = accept && req0_valid && (gnt == ID_W'(0));
    req1_ready = accept && req1_valid && (gnt == ID_W'(1));
    rom_addr   = (gnt == ID_W'(1)) ? req1_addr : req0_addr;

    state_d = state_q;
    id_d    = id_q;
    last_d  = last_q;
    data_d  = data_q;
    if (accept) begin
      state_d = RESP;
      id_d    = gnt;
      last_d  = gnt;
      data_d  = rom_data;
    end else if (take) begin
      state_d = IDLE;
      data_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      id_q    <= ID_W'(0);
      last_q  <= ID_W'(1);
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      last_q  <= last_d;
      data_q  <= data_d;
    end
  end

  assign rsp0_valid = (state_q == RESP) && (id_q == ID_W'(0));
  assign rsp1_valid = (state_q == RESP) && (id_q == ID_W'(1));
  assign rsp0_data  = rsp0_valid ? data_q : '0;
  assign rsp1_data  = rsp1_valid ? data_q : '0;

endmodule

// File: tb/tb_rom_arbiter.sv
// Bench for rom_arbiter: a round-robin and a fixed-priority instance run side by side
// against a transaction-level model, plus directed scenarios with literal expectations.
module tb_rom_arbiter;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v0[2], v1[2], rr0[2], rr1[2];
  logic [2:0] a0[2], a1[2];
  logic       rd0[2], rd1[2], rv0[2], rv1[2];
  logic [7:0] rdat0[2], rdat1[2];

  int total = 0;
  int bad   = 0;

  logic [7:0] rom_tab [8] = '{8'h33, 8'hCC, 8'h55, 8'hAA, 8'hF0, 8'h0F, 8'h81, 8'h7E};

  always #5 clk = ~clk;

  rom_arbiter #(.FAIR(1)) dut_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0[0]), .req0_addr(a0[0]), .req0_ready(rd0[0]),
    .rsp0_valid(rv0[0]), .rsp0_data(rdat0[0]), .rsp0_ready(rr0[0]),
    .req1_valid(v1[0]), .req1_addr(a1[0]), .req1_ready(rd1[0]),
    .rsp1_valid(rv1[0]), .rsp1_data(rdat1[0]), .rsp1_ready(rr1[0])
  );

  rom_arbiter #(.FAIR(0)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(v0[1]), .req0_addr(a0[1]), .req0_ready(rd0[1]),
    .rsp0_valid(rv0[1]), .rsp0_data(rdat0[1]), .rsp0_ready(rr0[1]),
    .req1_valid(v1[1]), .req1_addr(a1[1]), .req1_ready(rd1[1]),
    .rsp1_valid(rv1[1]), .rsp1_data(rdat1[1]), .rsp1_ready(rr1[1])
  );

  task automatic chk(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut=%0d got=%h want=%h t=%0t", nm, d, act, exp, $time);
    end
  endtask

  // Model state: the held response (if any) and who won the last grant.
  bit         m_hv[2]   = '{1'b0, 1'b0};
  int         m_id[2]   = '{0, 0};
  logic [7:0] m_dat[2]  = '{8'h00, 8'h00};
  int         m_last[2] = '{1, 1};

  always @(negedge clk) begin
    bit taken;
    int win;
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_hv[d] = 1'b0; m_dat[d] = 8'h00; m_last[d] = 1;
        chk("rst_rv0", d, 32'(rv0[d]), 32'd0);
        chk("rst_rv1", d, 32'(rv1[d]), 32'd0);
        chk("rst_dat0", d, 32'(rdat0[d]), 32'd0);
        chk("rst_dat1", d, 32'(rdat1[d]), 32'd0);
      end else begin
        taken = m_hv[d] && ((m_id[d] == 0) ? rr0[d] : rr1[d]);
        win = -1;
        if (v0[d] && v1[d]) win = (d == 0) ? 1 - m_last[d] : 0;
        else if (v0[d]) win = 0;
        else if (v1[d]) win = 1;
        if (m_hv[d] && !taken) win = -1;
        chk("m_rdy0", d, 32'(rd0[d]), 32'(win == 0));
        chk("m_rdy1", d, 32'(rd1[d]), 32'(win == 1));
        chk("m_rv0", d, 32'(rv0[d]), 32'(m_hv[d] && m_id[d] == 0));
        chk("m_rv1", d, 32'(rv1[d]), 32'(m_hv[d] && m_id[d] == 1));
        chk("m_dat0", d, 32'(rdat0[d]), (m_hv[d] && m_id[d] == 0) ? 32'(m_dat[d]) : 32'd0);
        chk("m_dat1", d, 32'(rdat1[d]), (m_hv[d] && m_id[d] == 1) ? 32'(m_dat[d]) : 32'd0);
        if (win >= 0) begin
          m_hv[d] = 1'b1; m_id[d] = win; m_last[d] = win;
          m_dat[d] = rom_tab[(win == 0) ? a0[d] : a1[d]];
        end else if (taken) begin
          m_hv[d] = 1'b0;
        end
      end
    end
  end

  task automatic idle_inputs();
    for (int d = 0; d < 2; d++) begin
      v0[d] = 0; v1[d] = 0; rr0[d] = 0; rr1[d] = 0; a0[d] = 0; a1[d] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    tick(); rst_n = 0;
    tick(); rst_n = 1;
  endtask

  initial begin
    idle_inputs();
    #12;
    chk("reset_rv0", 0, 32'(rv0[0]), 32'd0);
    chk("reset_rv1", 0, 32'(rv1[0]), 32'd0);
    chk("reset_dat1", 1, 32'(rdat1[1]), 32'd0);
    tick(); rst_n = 1;

    // First read after reset: requester 0, address 0.
    v0[0] = 1; a0[0] = 3'd0; rr0[0] = 1;
    #1 chk("first_rdy0", 0, 32'(rd0[0]), 32'd1);
    tick(); v0[0] = 0;
    #1 chk("first_rv0", 0, 32'(rv0[0]), 32'd1);
    chk("first_dat0", 0, 32'(rdat0[0]), 32'h33);

    // Both valid every cycle: grants alternate starting with requester 0.
    do_reset();
    v0[0] = 1; a0[0] = 3'd2; v1[0] = 1; a1[0] = 3'd3; rr0[0] = 1; rr1[0] = 1;
    #1 chk("alt_rdy0", 0, 32'(rd0[0]), 32'd1);
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #2;
      if (k < 4) begin
        chk("alt_rdy0", 0, 32'(rd0[0]), (k % 2 == 0) ? 32'd1 : 32'd0);
        chk("alt_rdy1", 0, 32'(rd1[0]), (k % 2 == 1) ? 32'd1 : 32'd0);
      end
      if (k % 2 == 1) begin
        chk("alt_rv0", 0, 32'(rv0[0]), 32'd1);
        chk("alt_dat0", 0, 32'(rdat0[0]), 32'h55);
      end else begin
        chk("alt_rv1", 0, 32'(rv1[0]), 32'd1);
        chk("alt_dat1", 0, 32'(rdat1[0]), 32'hAA);
      end
    end
    v0[0] = 0; v1[0] = 0;

    // Stalled response on requester 1 blocks requester 0.
    do_reset();
    v1[0] = 1; a1[0] = 3'd4; rr1[0] = 0;
    #1 chk("stall_rdy1", 0, 32'(rd1[0]), 32'd1);
    tick(); v1[0] = 0; v0[0] = 1; a0[0] = 3'd0; rr0[0] = 1;
    #1 chk("stall_rdy0", 0, 32'(rd0[0]), 32'd0);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin tick(); #1; end
      chk("stall_dat1", 0, 32'(rdat1[0]), 32'hF0);
      chk("stall_rdy0", 0, 32'(rd0[0]), 32'd0);
      chk("stall_rv0", 0, 32'(rv0[0]), 32'd0);
    end
    rr1[0] = 1;
    #1 chk("release_rdy0", 0, 32'(rd0[0]), 32'd1);
    tick(); v0[0] = 0; rr1[0] = 0;
    #1 chk("release_rv0", 0, 32'(rv0[0]), 32'd1);
    chk("release_dat0", 0, 32'(rdat0[0]), 32'h33);
    chk("release_rv1", 0, 32'(rv1[0]), 32'd0);

    // Fixed priority: requester 0 always wins.
    do_reset();
    v0[1] = 1; a0[1] = 3'd7; v1[1] = 1; a1[1] = 3'd1; rr0[1] = 1; rr1[1] = 1;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      #1;
      chk("fp_rdy0", 1, 32'(rd0[1]), 32'd1);
      chk("fp_rdy1", 1, 32'(rd1[1]), 32'd0);
      if (k > 0) begin
        chk("fp_dat0", 1, 32'(rdat0[1]), 32'h7E);
        chk("fp_rv1", 1, 32'(rv1[1]), 32'd0);
      end
    end
    v0[1] = 0; v1[1] = 0;

    // Reset while a response is held discards it.
    do_reset();
    v0[0] = 1; a0[0] = 3'd5; rr0[0] = 0;
    tick(); v0[0] = 0;
    #1 chk("hold_dat0", 0, 32'(rdat0[0]), 32'h0F);
    rst_n = 0;
    #1 chk("async_rv0", 0, 32'(rv0[0]), 32'd0);
    tick(); rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      tick(); #1;
      chk("post_rst_rv0", 0, 32'(rv0[0]), 32'd0);
      chk("post_rst_rv1", 0, 32'(rv1[0]), 32'd0);
    end
    rr0[0] = 0;

    // Address sweep from requester 1, back to back.
    do_reset();
    rr1[0] = 1;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) tick();
      if (i < 8) begin v1[0] = 1; a1[0] = 3'(i); end
      else v1[0] = 0;
      #1;
      if (i < 8) chk("sweep_rdy1", 0, 32'(rd1[0]), 32'd1);
      if (i > 0) begin
        case (i - 1)
          0: chk("sweep_dat", 0, 32'(rdat1[0]), 32'h33);
          1: chk("sweep_dat", 0, 32'(rdat1[0]), 32'hCC);
          2: chk("sweep_dat", 0, 32'(rdat1[0]), 32'h55);
          3: chk("sweep_dat", 0, 32'(rdat1[0]), 32'hAA);
          4: chk("sweep_dat", 0, 32'(rdat1[0]), 32'hF0);
          5: chk("sweep_dat", 0, 32'(rdat1[0]), 32'h0F);
          6: chk("sweep_dat", 0, 32'(rdat1[0]), 32'h81);
          default: chk("sweep_dat", 0, 32'(rdat1[0]), 32'h7E);
        endcase
      end
    end

    // Random traffic on both instances, with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      tick();
      if (!rst_n) rst_n = 1;
      else if ($urandom_range(0, 299) == 0) rst_n = 0;
      for (int d = 0; d < 2; d++) begin
        v0[d]  = ($urandom_range(0, 3) != 0);
        v1[d]  = ($urandom_range(0, 3) != 0);
        a0[d]  = 3'($urandom_range(0, 7));
        a1[d]  = 3'($urandom_range(0, 7));
        rr0[d] = ($urandom_range(0, 2) != 0);
        rr1[d] = ($urandom_range(0, 2) != 0);
      end
    end

    tick(); idle_inputs(); rst_n = 1;
    repeat (2) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
